// File: rtl/irrigation_zone_scheduler_pkg.sv
// Shared types for the irrigation zone scheduler.
//   state_t     : FSM state encoding
//   MODE_ASP/GOT: latched irrigation mode values (Mode[i]=1 sprinkler, 0 drip)
//   cmd_t       : machine command bundle decoded from state and mode
// Grant is one-hot: bit z set selects the valve of zone z, all-zero means no valve open.
package irrigation_zone_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_IRRIGATE = 3'd2,
    ST_CLEAN    = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  localparam logic MODE_ASP = 1'b1;
  localparam logic MODE_GOT = 1'b0;

  typedef struct packed {
    logic fill;
    logic asp;
    logic got;
    logic clean;
    logic busy;
    logic fault;
  } cmd_t;

  // Command decode; commands are mutually exclusive by construction.
  function automatic cmd_t decode_cmd(input state_t st, input logic mode);
    cmd_t c;
    c       = '0;
    c.fill  = (st == ST_FILL);
    c.asp   = (st == ST_IRRIGATE) && (mode == MODE_ASP);
    c.got   = (st == ST_IRRIGATE) && (mode == MODE_GOT);
    c.clean = (st == ST_CLEAN);
    c.busy  = (st != ST_IDLE);
    c.fault = (st == ST_ERROR);
    return c;
  endfunction

endpackage

// File: rtl/irrigation_zone_scheduler_rr_arbiter.sv
// Round-robin arbiter: selects the first set request at or after ptr, wrapping.
//   Req     : request vector
//   ptr     : highest-priority zone index
//   winner  : one-hot winner (zero if no request)
//   win_idx : index of the winner (0 if no request)
module irrigation_zone_scheduler_rr_arbiter #(
  parameter int unsigned N_ZONES = 4
) (
  input  logic [N_ZONES-1:0]         Req,
  input  logic [$clog2(N_ZONES)-1:0] ptr,
  output logic [N_ZONES-1:0]         winner,
  output logic [$clog2(N_ZONES)-1:0] win_idx
);

  localparam int unsigned ZW = $clog2(N_ZONES);

  logic          found;
  int unsigned   j;
  logic [ZW-1:0] idx;

  // Scan from ptr upward with wrap; first hit wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    j       = 0;
    idx     = '0;
    for (int unsigned i = 0; i < N_ZONES; i++) begin
      j   = (32'(ptr) + i) % N_ZONES;
      idx = ZW'(j);
      if (!found && Req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    winner = found ? (N_ZONES'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Irrigation zone scheduler: shares one tank/pump machine among N_ZONES zones.
// Round-robin zone selection, tank fill ordering, timed sprinkler/drip window,
// periodic cleaning pass, and an error park state.
//   Clock, Reset        : clock (rising edge), async active-high reset
//   Req[i], Mode[i]     : zone i request, zone i mode (1 sprinkler, 0 drip), sampled at grant
//   Tank_Full, Err      : asynchronous field inputs, 2-flop synchronised
//   Grant               : one-hot valve select of the zone being irrigated
//   Cmd_Fill/Asp/Got/Clean : machine commands, mutually exclusive
//   Busy, Fault         : not IDLE, in ERROR
module irrigation_zone_scheduler
  import irrigation_zone_scheduler_pkg::*;
#(
  parameter int unsigned N_ZONES     = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned T_ASP       = 100,
  parameter int unsigned T_GOT       = 200,
  parameter int unsigned T_CLEAN     = 50,
  parameter int unsigned CLEAN_EVERY = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [N_ZONES-1:0] Req,
  input  logic [N_ZONES-1:0] Mode,
  input  logic               Tank_Full,
  input  logic               Err,
  output logic [N_ZONES-1:0] Grant,
  output logic               Cmd_Fill,
  output logic               Cmd_Asp,
  output logic               Cmd_Got,
  output logic               Cmd_Clean,
  output logic               Busy,
  output logic               Fault
);

  localparam int unsigned ZW = $clog2(N_ZONES);
  localparam int unsigned CW = $clog2(CLEAN_EVERY + 1);

  state_t             state_q, state_d;
  logic [ZW-1:0]      zone_q, zone_d;
  logic               mode_q, mode_d;
  logic [ZW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               tank_m, tank_s;
  logic               err_m, err_s;
  logic [N_ZONES-1:0] winner;
  logic [ZW-1:0]      win_idx;
  logic [N_ZONES-1:0] grant_d;
  cmd_t               cmd_d;

  // Two-flop synchronisers for the field inputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tank_m <= 1'b0;
      tank_s <= 1'b0;
      err_m  <= 1'b0;
      err_s  <= 1'b0;
    end else begin
      tank_m <= Tank_Full;
      tank_s <= tank_m;
      err_m  <= Err;
      err_s  <= err_m;
    end
  end

  irrigation_zone_scheduler_rr_arbiter #(
    .N_ZONES (N_ZONES)
  ) u_arb (
    .Req     (Req),
    .ptr     (ptr_q),
    .winner  (winner),
    .win_idx (win_idx)
  );

  // State and datapath registers; outputs are registered decodes of the next state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      zone_q    <= '0;
      mode_q    <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      Grant     <= '0;
      Cmd_Fill  <= 1'b0;
      Cmd_Asp   <= 1'b0;
      Cmd_Got   <= 1'b0;
      Cmd_Clean <= 1'b0;
      Busy      <= 1'b0;
      Fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      zone_q    <= zone_d;
      mode_q    <= mode_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      Grant     <= grant_d;
      Cmd_Fill  <= cmd_d.fill;
      Cmd_Asp   <= cmd_d.asp;
      Cmd_Got   <= cmd_d.got;
      Cmd_Clean <= cmd_d.clean;
      Busy      <= cmd_d.busy;
      Fault     <= cmd_d.fault;
    end
  end

  // Next-state logic. Every IRRIGATE cycle consumes one timer count, including
  // the cycle in which a tank drop is seen, so FILL pauses never shorten the window.
  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    mode_d  = mode_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    if (err_s) begin
      state_d = ST_ERROR;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|winner) begin
            zone_d  = win_idx;
            mode_d  = Mode[win_idx];
            timer_d = (Mode[win_idx] == MODE_ASP) ? CNT_W'(T_ASP - 1) : CNT_W'(T_GOT - 1);
            state_d = tank_s ? ST_IRRIGATE : ST_FILL;
          end
        end
        ST_FILL: begin
          if (tank_s) state_d = ST_IRRIGATE;
        end
        ST_IRRIGATE: begin
          if (timer_q == '0) begin
            ptr_d = (zone_q == ZW'(N_ZONES - 1)) ? '0 : zone_q + ZW'(1);
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(CLEAN_EVERY - 1)) begin
              timer_d = CNT_W'(T_CLEAN - 1);
              state_d = ST_CLEAN;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            timer_d = timer_q - CNT_W'(1);
            if (!tank_s) state_d = ST_FILL;
          end
        end
        ST_CLEAN: begin
          if (timer_q == '0) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        ST_ERROR: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode of the next state, so registered outputs track the state register.
  always_comb begin
    cmd_d   = decode_cmd(state_d, mode_d);
    grant_d = (state_d == ST_IRRIGATE) ? (N_ZONES'(1) << zone_d) : '0;
  end

endmodule
